// File: rtl/mlp_chain_pkg.sv
// Shared types and helpers for the inter-layer CIM sequencer (mlp_chain_seq).
package mlp_chain_pkg;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        RUN       = 2'd3
    } link_state_t;

    localparam int DEF_NUM_LAYERS = 5;
    localparam int DEF_LAYER_SIZE [DEF_NUM_LAYERS+1] = '{784, 784, 1000, 500, 250, 10};

    function automatic int addr_w(input int max_size);
        return (max_size > 1) ? $clog2(max_size) : 1;
    endfunction

endpackage

// File: rtl/mlp_chain_if.sv
// Host-side streams of the sequencer: sample input stream and result output stream.
interface mlp_chain_if #(parameter int DW = 2);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport master (output s_valid, s_data, m_ready,
                    input  s_ready, m_valid, m_data, m_last);
    modport slave  (input  s_valid, s_data, m_ready,
                    output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/mlp_chain_link.sv
// One link: fills a layer's input buffer, pulses start, tracks busy.
// Optional per-link perf counters under MLP_CHAIN_PERF_EN.
module mlp_chain_link
    import mlp_chain_pkg::*;
#(
    parameter int DW   = 2,
    parameter int AW   = 10,
    parameter int SIZE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          hold,
    output logic          ibuf_we,
    output logic [AW-1:0] ibuf_addr,
    output logic [DW-1:0] ibuf_wr_data,
    output logic          start,
    input  logic          busy,
    output logic          busy_err
`ifdef MLP_CHAIN_PERF_EN
    ,
    output logic [31:0]   perf_run,
    output logic [31:0]   perf_frames
`endif
);
    localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

    link_state_t   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d, addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          we_q, we_d, start_q, start_d, busy_prev_q, busy_prev_d;
    logic          accept;

    assign accept = src_valid && (state_q == FILL);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        we_d        = accept;
        // START is decoded into a registered pulse so it trails the last write by a cycle
        start_d     = (state_q == START);
        busy_prev_d = busy;
        if (accept) begin
            addr_d = cnt_q;
            data_d = src_data;
        end
        unique case (state_q)
            FILL: if (accept) begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (busy)  state_d = RUN;
            RUN:       if (!busy) state_d = FILL;
            default:   state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            start_q     <= 1'b0;
            busy_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            start_q     <= start_d;
            busy_prev_q <= busy_prev_d;
        end
    end

    assign hold         = (state_q != FILL);
    assign ibuf_we      = we_q;
    assign ibuf_addr    = addr_q;
    assign ibuf_wr_data = data_q;
    assign start        = start_q;
    assign busy_err     = busy && !busy_prev_q && (state_q != WAIT_BUSY);

`ifdef MLP_CHAIN_PERF_EN
    logic [31:0] run_q, run_d, frames_q, frames_d;

    always_comb begin
        run_d    = run_q;
        frames_d = frames_q;
        if ((state_q == RUN) && (run_q != '1)) run_d = run_q + 32'd1;
        if (start_q) frames_d = frames_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q    <= '0;
            frames_q <= '0;
        end else begin
            run_q    <= run_d;
            frames_q <= frames_d;
        end
    end

    assign perf_run    = run_q;
    assign perf_frames = frames_q;
`endif

endmodule

// File: rtl/mlp_chain_seq.sv
// N-layer CIM chain sequencer: source muxing per link, result stream counter, sticky error.
// Define MLP_CHAIN_PERF_EN to add per-link RUN-cycle/frame counters and the perf read port.
module mlp_chain_seq
    import mlp_chain_pkg::*;
#(
    parameter  int NUM_LAYERS                 = DEF_NUM_LAYERS,
    parameter  int DATATYPE_SIZE              = 2,
    parameter  int MAX_SIZE                   = 1024,
    parameter  int LAYER_SIZE [NUM_LAYERS+1]  = DEF_LAYER_SIZE,
    localparam int ADDR_W                     = addr_w(MAX_SIZE),
    localparam int SEL_W                      = addr_w(NUM_LAYERS)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    mlp_chain_if.slave                              bus,
    output logic [NUM_LAYERS-1:0]                   o_ibuf_we,
    output logic [NUM_LAYERS-1:0][ADDR_W-1:0]       o_ibuf_addr,
    output logic [NUM_LAYERS-1:0][DATATYPE_SIZE-1:0] o_ibuf_wr_data,
    output logic [NUM_LAYERS-1:0]                   o_start,
    input  logic [NUM_LAYERS-1:0]                   i_busy,
    input  logic [NUM_LAYERS-1:0]                   i_out_valid,
    input  logic [NUM_LAYERS-1:0][DATATYPE_SIZE-1:0] i_out_data,
    output logic [NUM_LAYERS-1:0]                   o_hold,
    output logic                                    o_err
`ifdef MLP_CHAIN_PERF_EN
    ,
    input  logic [SEL_W-1:0]                        i_perf_sel,
    output logic [31:0]                             o_perf_run,
    output logic [31:0]                             o_perf_frames
`endif
);
    localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(LAYER_SIZE[NUM_LAYERS] - 1);

    logic [NUM_LAYERS-1:0]                    src_valid, link_hold, busy_err;
    logic [NUM_LAYERS-1:0][DATATYPE_SIZE-1:0] src_data;
`ifdef MLP_CHAIN_PERF_EN
    logic [NUM_LAYERS-1:0][31:0]              perf_run, perf_frames;
`endif

    assign src_valid[0] = bus.s_valid;
    assign src_data[0]  = bus.s_data;
    assign bus.s_ready  = !link_hold[0];

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_link
        if (k > 0) begin : g_src
            assign src_valid[k] = i_out_valid[k-1];
            assign src_data[k]  = i_out_data[k-1];
        end
        // A layer is held while the link it feeds is not filling
        if (k < NUM_LAYERS - 1) begin : g_hold
            assign o_hold[k] = link_hold[k+1];
        end else begin : g_hold_out
            assign o_hold[k] = !bus.m_ready;
        end

        mlp_chain_link #(
            .DW   (DATATYPE_SIZE),
            .AW   (ADDR_W),
            .SIZE (LAYER_SIZE[k])
        ) u_link (
            .clk          (clk),
            .rst          (rst),
            .src_valid    (src_valid[k]),
            .src_data     (src_data[k]),
            .hold         (link_hold[k]),
            .ibuf_we      (o_ibuf_we[k]),
            .ibuf_addr    (o_ibuf_addr[k]),
            .ibuf_wr_data (o_ibuf_wr_data[k]),
            .start        (o_start[k]),
            .busy         (i_busy[k]),
            .busy_err     (busy_err[k])
`ifdef MLP_CHAIN_PERF_EN
            ,
            .perf_run     (perf_run[k]),
            .perf_frames  (perf_frames[k])
`endif
        );
    end

    logic [ADDR_W-1:0] ocnt_q, ocnt_d;
    logic              err_q, err_d;

    assign bus.m_valid = i_out_valid[NUM_LAYERS-1];
    assign bus.m_data  = i_out_data[NUM_LAYERS-1];
    assign bus.m_last  = bus.m_valid && (ocnt_q == OUT_LAST);
    assign o_err       = err_q;

    always_comb begin
        ocnt_d = ocnt_q;
        if (bus.m_valid && bus.m_ready) ocnt_d = (ocnt_q == OUT_LAST) ? '0 : ocnt_q + 1'b1;
        err_d = err_q | (|(i_out_valid & o_hold)) | (|busy_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ocnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            ocnt_q <= ocnt_d;
            err_q  <= err_d;
        end
    end

`ifdef MLP_CHAIN_PERF_EN
    logic [31:0] prun_q, prun_d, pfrm_q, pfrm_d;

    always_comb begin
        prun_d = '0;
        pfrm_d = '0;
        if (int'(i_perf_sel) < NUM_LAYERS) begin
            prun_d = perf_run[i_perf_sel];
            pfrm_d = perf_frames[i_perf_sel];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prun_q <= '0;
            pfrm_q <= '0;
        end else begin
            prun_q <= prun_d;
            pfrm_q <= pfrm_d;
        end
    end

    assign o_perf_run    = prun_q;
    assign o_perf_frames = pfrm_q;
`endif

endmodule

// File: tb/tb_mlp_chain_seq.sv
// Scoreboard bench for mlp_chain_seq: two-layer chain 4->3->2 with behavioural layer models.
module tb_mlp_chain_seq;
    localparam int NL   = 2;
    localparam int DW   = 2;
    localparam int MAXS = 8;
    localparam int AW   = 3;
    localparam int LS [NL+1] = '{4, 3, 2};

    typedef struct { logic [DW-1:0] d; logic l; } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mlp_chain_if #(.DW(DW)) bus ();

    logic [NL-1:0]         o_ibuf_we, o_start, o_hold;
    logic [NL-1:0][AW-1:0] o_ibuf_addr;
    logic [NL-1:0][DW-1:0] o_ibuf_wr_data;
    logic [NL-1:0]         i_busy      = '0;
    logic [NL-1:0]         i_out_valid = '0;
    logic [NL-1:0][DW-1:0] i_out_data  = '0;
    logic                  o_err;
`ifdef MLP_CHAIN_PERF_EN
    logic [0:0]            i_perf_sel = '0;
    logic [31:0]           o_perf_run, o_perf_frames;
`endif

    mlp_chain_seq #(
        .NUM_LAYERS(NL), .DATATYPE_SIZE(DW), .MAX_SIZE(MAXS), .LAYER_SIZE(LS)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_ibuf_we(o_ibuf_we), .o_ibuf_addr(o_ibuf_addr), .o_ibuf_wr_data(o_ibuf_wr_data),
        .o_start(o_start), .i_busy(i_busy), .i_out_valid(i_out_valid), .i_out_data(i_out_data),
        .o_hold(o_hold), .o_err(o_err)
`ifdef MLP_CHAIN_PERF_EN
        , .i_perf_sel(i_perf_sel), .o_perf_run(o_perf_run), .o_perf_frames(o_perf_frames)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] lfn(int k, int i, logic [DW-1:0] a, logic [DW-1:0] b);
        int v;
        v = (k == 0) ? (int'(a) + 2 * int'(b) + i) : (int'(a) + 3 * int'(b) + i + 1);
        return DW'(v);
    endfunction

    // Layer models: capture buffer writes, go busy on start, then emit results when not held
    logic [DW-1:0] mem [NL][MAXS];
    logic [DW-1:0] outq [NL][$];
    res_t sb [$];
    int   bcnt [NL]      = '{0, 0};
    int   busy_len [NL]  = '{3, 3};
    int   wr_idx [NL]    = '{0, 0};
    int   start_cyc [NL] = '{-1, -1};
    int   we_cyc [NL]    = '{-1, -1};
    bit   inject0 = 1'b0;

    always @(negedge clk) begin
        res_t r;
        if (!rst) begin
            for (int k = 0; k < NL; k++) begin
                wr_idx[k] = 0;
                bcnt[k]   = 0;
                outq[k].delete();
            end
            i_busy      = '0;
            i_out_valid = '0;
        end else begin
            for (int k = 0; k < NL; k++) begin
                i_out_valid[k] = 1'b0;
                if (o_ibuf_we[k]) begin
                    chk($sformatf("ibuf_addr%0d", k), 32'(o_ibuf_addr[k]), 32'(wr_idx[k]));
                    mem[k][o_ibuf_addr[k]] = o_ibuf_wr_data[k];
                    wr_idx[k] = (wr_idx[k] + 1) % LS[k];
                    we_cyc[k] = cyc;
                end
                if (bcnt[k] > 0) begin
                    bcnt[k]--;
                    if (bcnt[k] == 0) i_busy[k] = 1'b0;
                end
                if (o_start[k]) begin
                    for (int i = 0; i < LS[k+1]; i++) outq[k].push_back(lfn(k, i, mem[k][i], mem[k][i+1]));
                    i_busy[k]    = 1'b1;
                    bcnt[k]      = busy_len[k];
                    start_cyc[k] = cyc;
                end
                if (!i_busy[k] && outq[k].size() > 0 && !o_hold[k]) begin
                    i_out_valid[k] = 1'b1;
                    i_out_data[k]  = outq[k].pop_front();
                end
            end
            if (inject0 && o_hold[0]) begin
                i_out_valid[0] = 1'b1;
                i_out_data[0]  = 2'd1;
                inject0        = 1'b0;
            end
        end
        #2;
        if (rst && bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) chk("sb_extra", 32'd1, 32'd0);
            else begin
                r = sb.pop_front();
                chk("m_data", 32'(bus.m_data), 32'(r.d));
                chk("m_last", 32'(bus.m_last), 32'(r.l));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, output int acc);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (!bus.s_ready && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("s_ready_timeout", 32'd0, 32'd1);
        acc = cyc;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic send_frame(output int acc);
        logic [DW-1:0] x [MAXS];
        logic [DW-1:0] y [MAXS];
        res_t r;
        for (int i = 0; i < LS[0]; i++) x[i] = DW'($urandom_range(0, 3));
        for (int i = 0; i < LS[1]; i++) y[i] = lfn(0, i, x[i], x[i+1]);
        for (int i = 0; i < LS[2]; i++) begin
            r.d = lfn(1, i, y[i], y[i+1]);
            r.l = (i == LS[2] - 1);
            sb.push_back(r);
        end
        for (int i = 0; i < LS[0]; i++) send(x[i], acc);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() > 0 || outq[0].size() > 0 || outq[1].size() > 0 || i_busy != '0) && n < 600) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        tick(2);
    endtask

    task automatic wait_busy1();
        int n = 0;
        while (!i_busy[1] && n < 100) begin
            tick();
            n++;
        end
        chk("busy1_seen", 32'(i_busy[1]), 32'd1);
    endtask

    initial begin
        int acc, n;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        tick(3);
        chk("rst_we", 32'(o_ibuf_we), 32'd0);
        chk("rst_start", 32'(o_start), 32'd0);
        chk("rst_hold", 32'(o_hold), 32'd0);
        chk("rst_addr", 32'(o_ibuf_addr), 32'd0);
        chk("rst_wdata", 32'(o_ibuf_wr_data), 32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("rst_m_last", 32'(bus.m_last), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        rst = 1'b1;
        tick(2);

        // partial frame then reset: address counter must restart
        send(2'd3, acc);
        send(2'd2, acc);
        tick();
        chk("mid_addr_before", 32'(o_ibuf_addr[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_addr_rst", 32'(o_ibuf_addr[0]), 32'd0);
        chk("mid_s_ready_rst", 32'(bus.s_ready), 32'd1);
        tick(2);
        rst = 1'b1;
        tick(2);

        // first full frame: write and start latency, hold rise
        send_frame(acc);
        chk("hold_rise", 32'(bus.s_ready), 32'd0);
        tick(2);
        chk("last_we_lat", 32'(we_cyc[0] - acc), 32'd1);
        chk("start_lat", 32'(start_cyc[0] - acc), 32'd2);
        drain();

        // back-to-back frames pipeline across layers
        for (int f = 0; f < 3; f++) send_frame(acc);
        drain();

        // layer 1 held busy: layer 0 must stall without loss
        busy_len[1] = 20;
        send_frame(acc);
        wait_busy1();
        send_frame(acc);
        tick(8);
        chk("hold0_busy1", 32'(o_hold[0]), 32'd1);
        chk("no_we1_held", 32'(o_ibuf_we[1]), 32'd0);
        drain();
        busy_len[1] = 3;

        // result backpressure
        bus.m_ready = 1'b0;
        send_frame(acc);
        n = 0;
        while (!(outq[1].size() > 0 && !i_busy[1]) && n < 200) begin
            tick();
            n++;
        end
        chk("res_pending", 32'(outq[1].size() > 0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("hold1_mready0", 32'(o_hold[1]), 32'd1);
            chk("mvalid_held", 32'(bus.m_valid), 32'd0);
            tick();
        end
        bus.m_ready = 1'b1;
        drain();
        chk("err_clean", 32'(o_err), 32'd0);

        // protocol violation: valid presented while held
        busy_len[1] = 10;
        send_frame(acc);
        wait_busy1();
        inject0 = 1'b1;
        tick(2);
        chk("err_set", 32'(o_err), 32'd1);
        drain();
        chk("err_sticky", 32'(o_err), 32'd1);
        rst = 1'b0;
        tick();
        chk("err_rst", 32'(o_err), 32'd0);
        rst = 1'b1;
        busy_len[1] = 3;
        tick(2);

`ifdef MLP_CHAIN_PERF_EN
        busy_len[0] = 10;
        send_frame(acc);
        send_frame(acc);
        drain();
        i_perf_sel = 1'b0;
        tick(2);
        chk("perf_run", o_perf_run, 32'd20);
        chk("perf_frames", o_perf_frames, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1, "timeout");
    end
endmodule
